// File: rtl/fifo_rd_stream_pkg.sv
// Shared types for the FIFO read-side stream adapter.
// Widths are sized for the largest legal prefetch depth so one set of types serves every build.
package fifo_rd_stream_pkg;
    localparam int DW_DEF        = 32;
    localparam int BUF_DEPTH_DEF = 3;
    localparam int BUF_DEPTH_MAX = 8;

    // Occupancy must represent 0..depth inclusive, hence depth+1 states.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int CNT_W = cnt_w(BUF_DEPTH_MAX);
    localparam int PTR_W = $clog2(BUF_DEPTH_MAX);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [PTR_W-1:0] ptr_t;
endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Circular prefetch buffer: storage, wr/rd pointers, occupancy count, head word output.
// Latency: push visible at head one cycle later; head is combinational from storage.
// Backpressure: none internally; the caller must never push while full.
module fifo_rd_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = BUF_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output cnt_t          count
);

    logic [DW-1:0] mem [DEPTH];
    ptr_t          wr_ptr;
    ptr_t          rd_ptr;

    // Explicit compare-and-clear so non-power-of-2 depths wrap correctly.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + cnt_t'(push) - cnt_t'(pop);
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO pop interface to valid/ready stream with prefetch; optional word counter (FIFO_RD_STREAM_CNT_EN).
// Latency: first m_valid two cycles after the first fifo_rd_en; 1 word/cycle sustained with BUF_DEPTH>=3.
// Backpressure: pops are credit-limited by registered occupancy; m_ready never reaches fifo_rd_en.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic          rd_clk,
    input  logic          rd_rst_n,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_rd_en,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [31:0]   rd_word_cnt
`endif
);

    logic inflight;
    logic drain;
    cnt_t count;
    cnt_t committed;

    // Buffered plus in-flight words are the credits already spent.
    assign committed  = count + cnt_t'(inflight);
    assign fifo_rd_en = rd_rst_n & ~fifo_empty & (committed < cnt_t'(BUF_DEPTH));

    assign m_valid = (count != '0);
    assign drain   = m_valid & m_ready;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    fifo_rd_skid_buf #(
        .DW    (DW),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (rd_clk),
        .rst_n     (rd_rst_n),
        .push      (inflight),
        .push_data (fifo_data),
        .pop       (drain),
        .head_data (m_data),
        .count     (count)
    );

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [31:0] word_cnt;

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            word_cnt <= '0;
        end else if (drain) begin
            word_cnt <= word_cnt + 32'd1;
        end
    end

    assign rd_word_cnt = word_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: FIFO source model feeds the adapter; a negedge monitor checks order, stability and pops.
module tb_fifo_rd_stream;

    logic        rd_clk = 1'b0;
    logic        rd_rst_n = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = '0;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [31:0] rd_word_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;
    int pop_cnt = 0;
    logic force_empty = 1'b0;
    logic rd_en_s = 1'b0;
    logic stall = 1'b0;
    logic [31:0] stall_data = '0;

    logic [31:0] src_q[$];
    logic [31:0] exp_q[$];

    fifo_rd_stream #(.DW(32), .BUF_DEPTH(3)) dut (
        .rd_clk     (rd_clk),
        .rd_rst_n   (rd_rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .rd_word_cnt(rd_word_cnt)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic upd_empty();
        fifo_empty = force_empty | (src_q.size() == 0);
    endtask

    task automatic push_word(input logic [31:0] w);
        src_q.push_back(w);
        exp_q.push_back(w);
        upd_empty();
    endtask

    task automatic cyc();
        @(posedge rd_clk);
        #1;
        upd_empty();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            cyc();
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    // Source FIFO model: registered data_out, one-cycle read latency.
    always @(posedge rd_clk) begin
        if (rd_en_s && src_q.size() > 0) begin
            fifo_data <= src_q.pop_front();
        end
    end

    // Monitor: all DUT outputs are stable at the falling edge.
    always @(negedge rd_clk) begin
        rd_en_s = fifo_rd_en;
        if (fifo_rd_en) pop_cnt++;
        if (!rd_rst_n) begin
            stall = 1'b0;
        end else begin
            chk("pop_while_empty", fifo_rd_en & fifo_empty, 0);
            if (stall) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, stall_data);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=0x%0h required=none at %0t", m_data, $time);
                end else begin
                    chk("data_order", m_data, exp_q.pop_front());
                end
                hs_cnt++;
            end
            stall = m_valid & ~m_ready;
            stall_data = m_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1: reset held with a non-empty FIFO
        for (int i = 0; i < 16; i++) push_word(i);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rst_rd_en", fifo_rd_en, 0);
            chk("rst_valid", m_valid, 0);
            chk("rst_data", m_data, 0);
        end

        // 2: full-rate stream of 0x0..0xF
        m_ready = 1'b1;
        rd_rst_n = 1'b1;
        #1;
        chk("first_pop", fifo_rd_en, 1);
        cyc();
        chk("lat_cycle1_valid", m_valid, 0);
        cyc();
        for (int i = 0; i < 16; i++) begin
            chk("stream_valid", m_valid, 1);
            cyc();
        end
        chk("stream_end_valid", m_valid, 0);
        chk("stream_count", hs_cnt, 16);
`ifdef FIFO_RD_STREAM_CNT_EN
        chk("word_cnt_16", rd_word_cnt, 16);
`endif

        // 3: backpressure fills exactly BUF_DEPTH entries
        m_ready = 1'b0;
        cyc();
        pop_cnt = 0;
        for (int i = 0; i < 16; i++) push_word(i);
        for (int i = 0; i < 10; i++) cyc();
        chk("bp_pops", pop_cnt, 3);
        chk("bp_rd_en", fifo_rd_en, 0);
        chk("bp_valid", m_valid, 1);
        chk("bp_head", m_data, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("bp_release_valid", m_valid, 1);
            cyc();
        end
        chk("bp_end_valid", m_valid, 0);

        // 4: FIFO runs empty after five words
        for (int i = 0; i < 5; i++) push_word(32'hA0 + i);
        wait_drain("empty_drain", 40);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("empty_valid", m_valid, 0);
            chk("empty_rd_en", fifo_rd_en, 0);
        end

        // 5: reset with two buffered words and one in flight
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(32'h100 + i);
        cyc();
        cyc();
        cyc();
        chk("pre_rst_valid", m_valid, 1);
        rd_rst_n = 1'b0;
        #1;
        chk("async_rst_valid", m_valid, 0);
        chk("async_rst_data", m_data, 0);
        chk("async_rst_rd_en", fifo_rd_en, 0);
        src_q.delete();
        exp_q.delete();
        hs_cnt = 0;
        upd_empty();
        cyc();
        cyc();
        rd_rst_n = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("post_rst_no_stale", m_valid, 0);
        end

        // Randomized traffic with random backpressure and empty glitches
        for (int i = 0; i < 3000; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            force_empty = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) != 0) push_word($urandom);
            else upd_empty();
            cyc();
        end
        force_empty = 1'b0;
        m_ready = 1'b1;
        upd_empty();
        wait_drain("random_drain", 200);
        cyc();
        cyc();
        chk("random_end_valid", m_valid, 0);
`ifdef FIFO_RD_STREAM_CNT_EN
        chk("word_cnt_random", rd_word_cnt, hs_cnt);
        dut.word_cnt = 32'hFFFF_FFFF;
        push_word(32'h5A5A);
        wait_drain("wrap_drain", 20);
        chk("word_cnt_wrap", rd_word_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
